branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Consumer side of the condition-code path: reads the registered NZP condition-code state (3-bit one-hot, N=100, Z=010, P=001, IDLE=000) and resolves conditional branches from the decoder's n/z/p mask.
- Owns the 16-bit program counter: sequential increment, PC-relative redirect on taken branches, and a one-cycle PC-control pulse.
- Stalls resolution while a condition-code write is still in flight.

Parameters:
RESET_PC, 16'h3000, PC value loaded on reset
WAIT_MAX, 8, max cycles spent in WAIT_CC before a forced resolve (range 1..255)

Ports:
clka  input  1  single clock, all state updates on rising edge
reset_in  input  1  asynchronous, active-high reset
pc_inc_in  input  1  advance PC by 1 (honoured only when the FSM is in IDLE)
br_valid_in  input  1  decoder presents a branch
br_n_in  input  1  branch mask bit n
br_z_in  input  1  branch mask bit z
br_p_in  input  1  branch mask bit p
br_offset_in  input  9  signed PC offset (two's complement)
cc_state_in  input  3  current condition-code state {N,Z,P}
cc_busy_in  input  1  a condition-code register write is pending
flush_in  input  1  synchronous abort of the branch in progress
br_ready_out  output  1  high when in IDLE; branch accepted on br_valid_in & br_ready_out
br_done_out  output  1  one-cycle pulse when a branch resolves
taken_out  output  1  resolution result, valid while br_done_out=1
pc_ctl_out  output  2  00 hold/seq, 01 redirect pulse, 10 forced-resolve pulse
pc_out  output  16  program counter
err_out  output  1  one-cycle pulse on WAIT_MAX timeout
taken_cnt_out  output  8  saturating count of taken branches

Behaviour:
- Reset (async, any state):
  - pc_out=RESET_PC; state=IDLE; br_ready_out=1.
  - br_done_out=0, taken_out=0, pc_ctl_out=00, err_out=0, taken_cnt_out=0.
  - Captured mask and offset cleared; wait counter cleared.
- States: IDLE, WAIT_CC, RESOLVE. All outputs are registered. br_ready_out = (state==IDLE).
- IDLE:
  - If pc_inc_in=1, then pc_out <= pc_out+1 (mod 2^16).
  - If br_valid_in=1: capture {n,z,p} and the offset. Next state is WAIT_CC if cc_busy_in=1, else RESOLVE.
  - Accept and pc_inc_in in the same cycle: both take effect. The increment is applied first, and the offset is later added to the incremented PC.
- WAIT_CC:
  - Wait counter increments each cycle while cc_busy_in=1.
  - cc_busy_in=0 -> RESOLVE, counter cleared.
  - Counter reaching WAIT_MAX -> RESOLVE; err_out pulses 1 cycle; the resolve cycle drives pc_ctl_out=10 instead of 01 if the branch is taken.
- RESOLVE (exactly one cycle), then IDLE with these updates:
  - taken = (mask==111) | |(mask & cc_state_in).
  - Mask 000 is never taken. cc_state_in=000 is not taken unless mask==111. A non-one-hot cc_state_in is treated as 000.
  - If taken: pc_out <= pc_out + sext16(offset) (wraps mod 2^16); pc_ctl_out pulses 01 (or 10, see WAIT_CC); taken_cnt_out increments, saturating at 255.
  - br_done_out=1 and taken_out=taken for exactly one cycle; both drop to 0 on the next edge.
- Latency, no stall: accept at edge k -> RESOLVE after edge k -> pc_out, br_done_out, taken_out valid after edge k+1 -> br_ready_out=1 after edge k+1.
- Back-to-back branches: the next accept is possible in the cycle br_done_out is high.
- pc_inc_in is ignored in WAIT_CC and RESOLVE (upstream stalls fetch).
- flush_in:
  - In WAIT_CC or RESOLVE: flush_in=1 -> IDLE next edge. No PC change, no br_done_out, no counter change.
  - In IDLE: flush_in=1 blocks accept that cycle, but pc_inc_in is still honoured.
  - flush_in beats timeout when both occur in the same cycle (no err_out).

Test Plan:
- Reset -> pc_out=16'h3000, br_ready_out=1, all pulse outputs 0; pulse pc_inc_in for 3 cycles -> pc_out=16'h3003.
- pc_out=16'h3000, cc_state_in=010, branch z=1, offset=9'h005, cc_busy_in=0 -> two edges later pc_out=16'h3005, taken_out=1, pc_ctl_out=01 for one cycle, taken_cnt_out=1.
- cc_state_in=100, mask 011, offset=9'h1FF -> not taken, pc_out unchanged, br_done_out=1, taken_out=0; then mask 111 with cc_state_in=000 -> taken, pc_out decremented by 1.
- cc_busy_in=1 for 3 cycles, then cc_state_in=001, mask p -> resolves 1 cycle after busy falls, err_out stays 0; hold cc_busy_in=1 for 8 cycles -> err_out pulse, pc_ctl_out=10 if taken.
- pc_out=16'hFFFE, offset=9'h004, taken -> pc_out=16'h0002 (wrap); 256 taken branches -> taken_cnt_out=255 and holds.
- flush_in during WAIT_CC -> IDLE, no br_done_out, PC unchanged; reset_in asserted mid-RESOLVE -> immediate return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Branch/condition-code bus between the decoder/fetch side (master) and
// branch_resolve_unit (slave).
//   master drives: pc_inc_in, br_valid_in, br_{n,z,p}_in, br_offset_in,
//                  cc_state_in, cc_busy_in, flush_in
//   slave drives : br_ready_out, br_done_out, taken_out, pc_ctl_out, pc_out,
//                  err_out, taken_cnt_out
interface branch_resolve_unit_if;
  logic        pc_inc_in;
  logic        br_valid_in;
  logic        br_n_in;
  logic        br_z_in;
  logic        br_p_in;
  logic [8:0]  br_offset_in;
  logic [2:0]  cc_state_in;
  logic        cc_busy_in;
  logic        flush_in;
  logic        br_ready_out;
  logic        br_done_out;
  logic        taken_out;
  logic [1:0]  pc_ctl_out;
  logic [15:0] pc_out;
  logic        err_out;
  logic [7:0]  taken_cnt_out;

  modport master (
    output pc_inc_in, br_valid_in, br_n_in, br_z_in, br_p_in, br_offset_in,
           cc_state_in, cc_busy_in, flush_in,
    input  br_ready_out, br_done_out, taken_out, pc_ctl_out, pc_out,
           err_out, taken_cnt_out
  );

  modport slave (
    input  pc_inc_in, br_valid_in, br_n_in, br_z_in, br_p_in, br_offset_in,
           cc_state_in, cc_busy_in, flush_in,
    output br_ready_out, br_done_out, taken_out, pc_ctl_out, pc_out,
           err_out, taken_cnt_out
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: owns the 16-bit PC, resolves conditional branches
// against the registered NZP condition-code state, and stalls while a
// condition-code write is pending (with a WAIT_MAX timeout).
//   clka     : clock, rising edge
//   reset_in : asynchronous active-high reset
//   bus      : branch_resolve_unit_if.slave (branch request, CC state,
//              PC/status outputs)
module branch_resolve_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int          WAIT_MAX = 8
) (
  input logic                  clka,
  input logic                  reset_in,
  branch_resolve_unit_if.slave bus
);

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RES} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [2:0]  mask_q;
  logic [8:0]  off_q;
  logic [7:0]  wcnt_q;
  logic        forced_q;
  logic        ready_q, done_q, taken_q, err_q;
  logic [1:0]  ctl_q;
  logic [7:0]  tcnt_q;

  logic [2:0]  cc_oh;
  logic        taken_d;
  logic [15:0] off_sext;
  logic [7:0]  wcnt_d;

  // Anything other than a clean one-hot code is treated as "no flags set".
  always_comb begin
    cc_oh = 3'b000;
    if (bus.cc_state_in == 3'b100 || bus.cc_state_in == 3'b010 ||
        bus.cc_state_in == 3'b001)
      cc_oh = bus.cc_state_in;
  end

  assign taken_d  = (mask_q == 3'b111) | (|(mask_q & cc_oh));
  assign off_sext = {{7{off_q[8]}}, off_q};
  assign wcnt_d   = wcnt_q + 8'd1;

  always_ff @(posedge clka or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      mask_q   <= 3'b000;
      off_q    <= 9'h000;
      wcnt_q   <= 8'h00;
      forced_q <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
      ctl_q    <= 2'b00;
      tcnt_q   <= 8'h00;
    end else begin
      // Pulse outputs default low every cycle.
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      ctl_q   <= 2'b00;
      case (state_q)
        S_IDLE: begin
          // Increment lands first; a branch accepted this cycle adds its
          // offset to the incremented PC when it resolves.
          if (bus.pc_inc_in) pc_q <= pc_q + 16'd1;
          if (bus.br_valid_in && !bus.flush_in) begin
            mask_q   <= {bus.br_n_in, bus.br_z_in, bus.br_p_in};
            off_q    <= bus.br_offset_in;
            forced_q <= 1'b0;
            wcnt_q   <= 8'h00;
            ready_q  <= 1'b0;
            state_q  <= bus.cc_busy_in ? S_WAIT : S_RES;
          end
        end
        S_WAIT: begin
          if (bus.flush_in) begin
            wcnt_q  <= 8'h00;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (!bus.cc_busy_in) begin
            wcnt_q  <= 8'h00;
            state_q <= S_RES;
          end else if (wcnt_d == WAIT_MAX_C) begin
            // Give up waiting; resolve against whatever CC state is present.
            wcnt_q   <= 8'h00;
            err_q    <= 1'b1;
            forced_q <= 1'b1;
            state_q  <= S_RES;
          end else begin
            wcnt_q <= wcnt_d;
          end
        end
        S_RES: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
          if (!bus.flush_in) begin
            done_q  <= 1'b1;
            taken_q <= taken_d;
            if (taken_d) begin
              pc_q  <= pc_q + off_sext;
              ctl_q <= forced_q ? 2'b10 : 2'b01;
              if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
            end
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.br_ready_out  = ready_q;
  assign bus.br_done_out   = done_q;
  assign bus.taken_out     = taken_q;
  assign bus.pc_ctl_out    = ctl_q;
  assign bus.pc_out        = pc_q;
  assign bus.err_out       = err_q;
  assign bus.taken_cnt_out = tcnt_q;

endmodule
